// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the MEM-stage cache access controller.
package mem_ctrl_pkg;

    // Sequencing states of the access controller.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOOKUP    = 3'd1,
        ST_MISS_WAIT = 3'd2,
        ST_WRITE     = 3'd3,
        ST_DONE      = 3'd4
    } mem_ctrl_state_t;

    // Default backing-memory fill latency in cycles.
    localparam int MEM_LATENCY_DEF = 4;

endpackage

// File: rtl/mem_wait_timer.sv
// Loadable 4-bit down-counter that times the backing-memory fill.
// Counts down by one per cycle until it reaches zero, then holds.
module mem_wait_timer (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       load,
    input  logic       clear,
    input  logic [3:0] value,
    output logic       zero
);

    logic [3:0] cnt_reg;

    // Clear wins over load so an aborted wait never leaves a stale count.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_reg <= 4'd0;
        end else if (clear) begin
            cnt_reg <= 4'd0;
        end else if (load) begin
            cnt_reg <= value;
        end else if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
        end
    end

    assign zero = (cnt_reg == 4'd0);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage cache sequencing controller: one operation at a time, stalls the
// pipeline across misses and fill latency, and splits SB into a lookup that
// latches the old word followed by a merge-write.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int MEM_LATENCY = MEM_LATENCY_DEF,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             req_valid,
    input  logic             req_write,
    input  logic             req_byte,
    input  logic             flush,
    input  logic             hit,
    output logic             cache_en,
    output logic             cache_write_en,
    output logic             merge_latch,
    output logic             merge_sel,
    output logic             stall,
    output logic             done,
    output logic             retry_err,
    output logic [CNT_W-1:0] access_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    // Wait counter is loaded with latency-1 so MISS_WAIT lasts MEM_LATENCY cycles.
    localparam logic [3:0] WAIT_LOAD = 4'(MEM_LATENCY - 1);

    mem_ctrl_state_t state_reg, state_next;

    logic retry_reg;
    logic retry_err_reg;
    logic [CNT_W-1:0] access_cnt_reg;
    logic [CNT_W-1:0] miss_cnt_reg;

    logic timer_load;
    logic timer_clear;
    logic timer_zero;
    logic miss_inc;
    logic acc_inc;
    logic retry_set;
    logic retry_clr;
    logic err_set;

    mem_wait_timer u_wait_timer (
        .clk   (clk),
        .rst_b (rst_b),
        .load  (timer_load),
        .clear (timer_clear),
        .value (WAIT_LOAD),
        .zero  (timer_zero)
    );

    // State register; a reset mid-operation drops whatever was in flight.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Retry flag marks the post-fill lookup; retry_err is sticky until reset.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            retry_reg     <= 1'b0;
            retry_err_reg <= 1'b0;
        end else begin
            if (retry_clr) begin
                retry_reg <= 1'b0;
            end else if (retry_set) begin
                retry_reg <= 1'b1;
            end
            if (err_set) begin
                retry_err_reg <= 1'b1;
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            access_cnt_reg <= '0;
            miss_cnt_reg   <= '0;
        end else begin
            if (acc_inc && (access_cnt_reg != {CNT_W{1'b1}})) begin
                access_cnt_reg <= access_cnt_reg + CNT_W'(1);
            end
            if (miss_inc && (miss_cnt_reg != {CNT_W{1'b1}})) begin
                miss_cnt_reg <= miss_cnt_reg + CNT_W'(1);
            end
        end
    end

    // Next-state and cache-control decode; flush aborts only before the write.
    always_comb begin
        state_next     = state_reg;
        cache_en       = 1'b0;
        cache_write_en = 1'b0;
        merge_latch    = 1'b0;
        merge_sel      = 1'b0;
        done           = 1'b0;
        timer_load     = 1'b0;
        timer_clear    = 1'b0;
        miss_inc       = 1'b0;
        acc_inc        = 1'b0;
        retry_set      = 1'b0;
        retry_clr      = 1'b0;
        err_set        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    state_next = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                cache_en = 1'b1;
                if (flush) begin
                    state_next  = ST_IDLE;
                    timer_clear = 1'b1;
                    retry_clr   = 1'b1;
                end else if (hit) begin
                    if (req_write) begin
                        // Old word is captured now so the byte merge is ready for WRITE.
                        state_next  = ST_WRITE;
                        merge_latch = req_byte;
                    end else begin
                        state_next = ST_DONE;
                    end
                end else begin
                    // Write-allocate: stores fill first, then retry the lookup.
                    state_next = ST_MISS_WAIT;
                    timer_load = 1'b1;
                    miss_inc   = 1'b1;
                    err_set    = retry_reg;
                end
            end
            ST_MISS_WAIT: begin
                cache_en = 1'b1;
                if (flush) begin
                    state_next  = ST_IDLE;
                    timer_clear = 1'b1;
                    retry_clr   = 1'b1;
                end else if (timer_zero) begin
                    state_next = ST_LOOKUP;
                    retry_set  = 1'b1;
                end
            end
            ST_WRITE: begin
                cache_en       = 1'b1;
                cache_write_en = 1'b1;
                merge_sel      = req_byte;
                state_next     = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                acc_inc    = 1'b1;
                retry_clr  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Stall follows req_valid combinationally so a new request freezes the
    // pipeline in the same cycle; it is forced low while reset is held.
    assign stall      = rst_b && req_valid && (state_reg != ST_DONE);
    assign retry_err  = retry_err_reg;
    assign access_cnt = access_cnt_reg;
    assign miss_cnt   = miss_cnt_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with MEM_LATENCY=4.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_b;
    logic        req_valid;
    logic        req_write;
    logic        req_byte;
    logic        flush;
    logic        hit;
    logic        cache_en;
    logic        cache_write_en;
    logic        merge_latch;
    logic        merge_sel;
    logic        stall;
    logic        done;
    logic        retry_err;
    logic [15:0] access_cnt;
    logic [15:0] miss_cnt;
    logic [5:0]  outs;

    int checks = 0;
    int errors = 0;

    mem_access_ctrl #(.MEM_LATENCY(4), .CNT_W(16)) dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_byte       (req_byte),
        .flush          (flush),
        .hit            (hit),
        .cache_en       (cache_en),
        .cache_write_en (cache_write_en),
        .merge_latch    (merge_latch),
        .merge_sel      (merge_sel),
        .stall          (stall),
        .done           (done),
        .retry_err      (retry_err),
        .access_cnt     (access_cnt),
        .miss_cnt       (miss_cnt)
    );

    // {cache_en, cache_write_en, merge_latch, merge_sel, stall, done}
    assign outs = {cache_en, cache_write_en, merge_latch, merge_sel, stall, done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %-18s observed=%0h expected=%0h ok", tag, obs, exp);
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_b = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0;
        flush = 1'b0; hit = 1'b0;
        #12;
        chk("reset_outs", 32'(outs), 32'h00);
        chk("reset_acc", 32'(access_cnt), 32'd0);
        chk("reset_miss", 32'(miss_cnt), 32'd0);
        chk("reset_err", 32'(retry_err), 32'd0);
        cyc(); rst_b = 1'b1;

        // Load hit: LOOKUP c1, DONE c2
        cyc(); req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; hit = 1'b0; #1;
        chk("ld_hit_c0", 32'(outs), 32'b000010);
        cyc(); hit = 1'b1; #1;
        chk("ld_hit_c1", 32'(outs), 32'b100010);
        cyc(); #1;
        chk("ld_hit_c2", 32'(outs), 32'b000001);
        req_valid = 1'b0; hit = 1'b0;
        cyc(); #1;
        chk("ld_hit_idle", 32'(outs), 32'b000000);
        chk("ld_hit_acc", 32'(access_cnt), 32'd1);
        chk("ld_hit_miss", 32'(miss_cnt), 32'd0);

        // SB hit: merge_latch c1, merge write c2, DONE c3
        cyc(); req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1; #1;
        chk("sb_hit_c0", 32'(outs), 32'b000010);
        cyc(); hit = 1'b1; #1;
        chk("sb_hit_c1", 32'(outs), 32'b101010);
        cyc(); #1;
        chk("sb_hit_c2", 32'(outs), 32'b110110);
        cyc(); #1;
        chk("sb_hit_c3", 32'(outs), 32'b000001);
        req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; hit = 1'b0;
        cyc(); #1;
        chk("sb_hit_acc", 32'(access_cnt), 32'd2);

        // Load miss: MISS_WAIT c2..c5, LOOKUP c6, DONE c7
        cyc(); req_valid = 1'b1; #1;
        chk("ld_miss_c0", 32'(outs), 32'b000010);
        cyc(); hit = 1'b0; #1;
        chk("ld_miss_c1", 32'(outs), 32'b100010);
        for (int i = 2; i <= 5; i++) begin
            cyc(); #1;
            chk($sformatf("ld_miss_c%0d", i), 32'(outs), 32'b100010);
        end
        cyc(); hit = 1'b1; #1;
        chk("ld_miss_c6", 32'(outs), 32'b100010);
        cyc(); #1;
        chk("ld_miss_c7", 32'(outs), 32'b000001);
        req_valid = 1'b0; hit = 1'b0;
        cyc(); #1;
        chk("ld_miss_cnt", 32'(miss_cnt), 32'd1);
        chk("ld_miss_acc", 32'(access_cnt), 32'd3);
        chk("ld_miss_err", 32'(retry_err), 32'd0);

        // Retry misses again: second wait c7..c10, LOOKUP c11, DONE c12
        cyc(); req_valid = 1'b1; #1;
        cyc(); hit = 1'b0; #1;
        chk("retry_c1", 32'(outs), 32'b100010);
        for (int i = 2; i <= 5; i++) begin
            cyc(); #1;
        end
        cyc(); #1;
        chk("retry_c6", 32'(outs), 32'b100010);
        chk("retry_err_pre", 32'(retry_err), 32'd0);
        for (int i = 7; i <= 10; i++) begin
            cyc(); #1;
            chk($sformatf("retry_c%0d", i), 32'(outs), 32'b100010);
        end
        chk("retry_err_set", 32'(retry_err), 32'd1);
        cyc(); hit = 1'b1; #1;
        chk("retry_c11", 32'(outs), 32'b100010);
        cyc(); #1;
        chk("retry_c12", 32'(outs), 32'b000001);
        req_valid = 1'b0; hit = 1'b0;
        cyc(); #1;
        chk("retry_err_hold", 32'(retry_err), 32'd1);
        chk("retry_miss_cnt", 32'(miss_cnt), 32'd3);
        chk("retry_acc", 32'(access_cnt), 32'd4);

        // Flush at second MISS_WAIT cycle
        cyc(); req_valid = 1'b1; #1;
        cyc(); hit = 1'b0; #1;
        cyc(); #1;
        chk("flush_mw1", 32'(outs), 32'b100010);
        cyc(); flush = 1'b1; #1;
        chk("flush_mw2", 32'(outs), 32'b100010);
        cyc(); flush = 1'b0; req_valid = 1'b0; #1;
        chk("flush_idle", 32'(outs), 32'b000000);
        cyc(); #1;
        chk("flush_nodone", 32'(outs), 32'b000000);
        chk("flush_acc", 32'(access_cnt), 32'd4);
        chk("flush_miss", 32'(miss_cnt), 32'd4);

        // Flush during WRITE of a SW hit is ignored
        cyc(); req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; #1;
        cyc(); hit = 1'b1; #1;
        chk("fw_c1", 32'(outs), 32'b100010);
        cyc(); flush = 1'b1; #1;
        chk("fw_c2", 32'(outs), 32'b110010);
        cyc(); flush = 1'b0; #1;
        chk("fw_c3", 32'(outs), 32'b000001);
        req_valid = 1'b0; req_write = 1'b0; hit = 1'b0;
        cyc(); #1;
        chk("fw_acc", 32'(access_cnt), 32'd5);

        // Reset pulsed during MISS_WAIT, then a fresh load hit
        cyc(); req_valid = 1'b1; #1;
        cyc(); hit = 1'b0; #1;
        cyc(); #1;
        chk("rst_mw", 32'(outs), 32'b100010);
        rst_b = 1'b0; #1;
        chk("rst_outs", 32'(outs), 32'b000000);
        chk("rst_acc", 32'(access_cnt), 32'd0);
        chk("rst_miss", 32'(miss_cnt), 32'd0);
        chk("rst_err", 32'(retry_err), 32'd0);
        cyc(); rst_b = 1'b1; #1;
        chk("rst_rel_c0", 32'(outs), 32'b000010);
        cyc(); hit = 1'b1; #1;
        chk("rst_rel_c1", 32'(outs), 32'b100010);
        cyc(); #1;
        chk("rst_rel_c2", 32'(outs), 32'b000001);
        req_valid = 1'b0; hit = 1'b0;
        cyc(); #1;
        chk("rst_rel_acc", 32'(access_cnt), 32'd1);
        chk("rst_rel_miss", 32'(miss_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
